pacman_pos_decoder: RTL and testbench
=====================================

# pacman_pos_decoder

Receive-side counterpart of the Pacman frame generator. Accepts a 1024-bit one-hot frame vector in which exactly one bit is set, at index = row*10 + col. Scans the frame sequentially and recovers the index, row and column. Classifies the movement against the previously reported position and flags malformed frames (no bit set, or more than one bit set).

## Interface
- No parameters; all dimensions are fixed constants in the package.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame  in  1024  one-hot video frame
- frame_valid  in  1  frame present; accepted when frame_valid && ready on a clk edge
- ready  out  1  high only in IDLE
- pos_valid  out  1  one-cycle pulse: new position reported
- pos_idx  out  10  decoded bit index
- pos_row  out  7  pos_idx / 10 (0..102)
- pos_col  out  4  pos_idx % 10 (0..9)
- dir  out  3  movement code, see Operation
- err_none  out  1  one-cycle pulse: frame had no set bit
- err_multi  out  1  one-cycle pulse: frame had more than one set bit

## Operation
- FSM states: IDLE, SCAN, DIV, REPORT.
- IDLE
  - ready=1.
  - On accept: latch frame into an internal register; the input may change afterwards.
  - Clear chunk counter, found and multi flags; go to SCAN.
- SCAN: 32 cycles, chunk k = frame_reg[32k+31:32k], k = 0..31.
  - Lowest set bit in chunk and no prior find: found=1, idx = 32k + bit.
  - Chunk holds ≥2 ones, or a one arrives while found=1: multi=1.
  - After k=31:
    - multi=1 → REPORT, error err_multi.
    - found=0 → REPORT, error err_none.
    - Otherwise → DIV with rem=idx, row=0.
- DIV: one step per cycle.
  - rem ≥ 10: rem −= 10, row += 1.
  - rem < 10: col = rem; go to REPORT.
- REPORT: one cycle, then IDLE.
  - Success:
    - pos_valid=1.
    - pos_idx, pos_row and pos_col update.
    - dir is computed from the 11-bit signed delta d = idx − prev_idx.
    - prev_idx = idx; prev_valid = 1.
  - Error:
    - The matching err_* pulses.
    - pos_* and dir hold their values.
    - prev_idx and prev_valid are unchanged.
- dir codes:
  - 0 NONE: prev_valid=0.
  - 1 STILL: d=0.
  - 2 RIGHT: d=+1.
  - 3 LEFT: d=−1.
  - 4 DOWN: d=+10.
  - 5 UP: d=−10.
  - 6 JUMP: any other d.
- Reset values: ready=1; pos_valid, err_none, err_multi, pos_idx, pos_row, pos_col, dir all 0; prev_valid=0; state IDLE.
- Reset mid-operation (any state): immediate return to IDLE with reset values; the in-flight frame is discarded and produces no pulse.
- frame_valid while ready=0 is ignored; no queueing.

## Timing
- Let E0 be the accepting edge.
- Edges E1..E32 process chunks 0..31.
- Success: E32 enters DIV; the DIV exit edge is E(33+row). pos_valid is high in the cycle following E(33+row).
  - Row 0: following E33.
  - Row 102 (idx 1023): following E135.
- Error: E32 enters REPORT; err_* is high in the cycle following E32.
- ready returns to 1 on the edge after REPORT. Next earliest accept is the edge after that.
- Outputs are registered; no combinational path from frame or frame_valid to any output.

## Structure
- Package pacman_pkg holds:
  - FRAME_W=1024, CHUNK_W=32, N_CHUNKS=32, GRID_COLS=10.
  - State enum.
  - dir_t enum with the codes above.
- One sub-module, pacman_prio_enc32: combinational.
  - In: 32-bit chunk.
  - Out: any, lowest-set-bit index (5 bits), multi (≥2 ones).

## Test plan
- Single bit at idx 0 from reset → pos_valid after E33; idx 0, row 0, col 0, dir NONE.
- Sequence 57, 58, 68, 67, 57, 57, 900 → rows/cols (5,7), (5,8), (6,8), (6,7), (5,7), (5,7), (90,0).
  - dir NONE, RIGHT, DOWN, LEFT, UP, STILL, JUMP.
  - First report after E38.
- All-zero frame → err_none after E32, no pos_valid, pos_* unchanged; next frame 58 after a prior 57 → dir RIGHT.
- Multi-bit frames:
  - Bits 5 and 700 → err_multi.
  - Bits 33 and 34 (same chunk) → err_multi.
  - Bit 1023 alone → row 102, col 3, pos_valid after E135.
- rst asserted during DIV of idx 1000 → immediate IDLE, no pulse, all outputs 0; next frame 12 → dir NONE.
- frame_valid held high continuously with changing frame → only frames present on accepting edges are decoded; back-to-back spacing equals the latency plus 2 edges.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared constants, FSM states and movement codes for the Pacman position decoder.
package pacman_pkg;

    localparam int FRAME_W     = 1024;
    localparam int CHUNK_W     = 32;
    localparam int N_CHUNKS    = 32;
    localparam int GRID_COLS   = 10;
    localparam int IDX_W       = 10;
    localparam int ROW_W       = 7;
    localparam int COL_W       = 4;
    localparam int CHUNK_SEL_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DIV,
        S_REPORT
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_STILL = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4,
        DIR_UP    = 3'd5,
        DIR_JUMP  = 3'd6
    } dir_t;

    function automatic dir_t classify_move(input logic             prev_valid,
                                           input logic [IDX_W-1:0] idx,
                                           input logic [IDX_W-1:0] prev_idx);
        logic signed [IDX_W:0] d;
        d = $signed({1'b0, idx}) - $signed({1'b0, prev_idx});
        if (!prev_valid)       return DIR_NONE;
        else if (d == 11'sd0)  return DIR_STILL;
        else if (d == 11'sd1)  return DIR_RIGHT;
        else if (d == -11'sd1) return DIR_LEFT;
        else if (d == 11'sd10) return DIR_DOWN;
        else if (d == -11'sd10) return DIR_UP;
        else                   return DIR_JUMP;
    endfunction

endpackage

// File: rtl/pacman_prio_enc32.sv
// Combinational 32-bit lowest-set-bit encoder; also flags chunks with two or more ones.
module pacman_prio_enc32
    import pacman_pkg::*;
(
    input  logic [CHUNK_W-1:0]     chunk_i,
    output logic                   any_o,
    output logic [CHUNK_SEL_W-1:0] low_o,
    output logic                   multi_o
);

    always_comb begin
        low_o = '0;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (chunk_i[i]) low_o = CHUNK_SEL_W'(i);
        end
    end

    assign any_o   = |chunk_i;
    // Clearing the lowest set bit leaves something only if another bit was set.
    assign multi_o = |(chunk_i & (chunk_i - 32'd1));

endmodule

// File: rtl/pacman_pos_decoder.sv
// Decodes a one-hot 1024-bit frame into index/row/col and a move code; 34+row cycles per frame.
// Accepts only while ready (IDLE); frame_valid at other times is dropped, nothing is queued.
module pacman_pos_decoder
    import pacman_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    output logic               ready,
    output logic               pos_valid,
    output logic [IDX_W-1:0]   pos_idx,
    output logic [ROW_W-1:0]   pos_row,
    output logic [COL_W-1:0]   pos_col,
    output logic [2:0]         dir,
    output logic               err_none,
    output logic               err_multi
);

    state_t                 state_q, state_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [CHUNK_SEL_W-1:0] chunk_q, chunk_d;
    logic                   found_q, found_d;
    logic                   multi_q, multi_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       rem_q, rem_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [IDX_W-1:0]       prev_idx_q, prev_idx_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   pos_valid_q, pos_valid_d;
    logic                   err_none_q, err_none_d;
    logic                   err_multi_q, err_multi_d;
    logic [IDX_W-1:0]       pos_idx_q, pos_idx_d;
    logic [ROW_W-1:0]       pos_row_q, pos_row_d;
    logic [COL_W-1:0]       pos_col_q, pos_col_d;
    dir_t                   dir_q, dir_d;

    logic [CHUNK_W-1:0]     chunk_dat;
    logic                   enc_any;
    logic [CHUNK_SEL_W-1:0] enc_low;
    logic                   enc_multi;

    assign chunk_dat = frame_q[{chunk_q, 5'd0} +: CHUNK_W];

    pacman_prio_enc32 u_enc (
        .chunk_i (chunk_dat),
        .any_o   (enc_any),
        .low_o   (enc_low),
        .multi_o (enc_multi)
    );

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        chunk_d      = chunk_q;
        found_d      = found_q;
        multi_d      = multi_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        row_d        = row_q;
        prev_idx_d   = prev_idx_q;
        prev_valid_d = prev_valid_q;
        pos_idx_d    = pos_idx_q;
        pos_row_d    = pos_row_q;
        pos_col_d    = pos_col_q;
        dir_d        = dir_q;
        pos_valid_d  = 1'b0;
        err_none_d   = 1'b0;
        err_multi_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    frame_d = frame;
                    chunk_d = '0;
                    found_d = 1'b0;
                    multi_d = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                chunk_d = chunk_q + 5'd1;
                if (enc_multi || (enc_any && found_q)) multi_d = 1'b1;
                if (enc_any && !found_q) begin
                    found_d = 1'b1;
                    idx_d   = {chunk_q, enc_low};
                end
                // The last chunk's contribution is folded in before deciding the outcome.
                if (chunk_q == 5'(N_CHUNKS - 1)) begin
                    if (multi_d) begin
                        err_multi_d = 1'b1;
                        state_d     = S_REPORT;
                    end else if (!found_d) begin
                        err_none_d = 1'b1;
                        state_d    = S_REPORT;
                    end else begin
                        rem_d   = idx_d;
                        row_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (rem_q >= 10'(GRID_COLS)) begin
                    rem_d = rem_q - 10'(GRID_COLS);
                    row_d = row_q + 7'd1;
                end else begin
                    pos_valid_d  = 1'b1;
                    pos_idx_d    = idx_q;
                    pos_row_d    = row_q;
                    pos_col_d    = rem_q[COL_W-1:0];
                    dir_d        = classify_move(prev_valid_q, idx_q, prev_idx_q);
                    prev_idx_d   = idx_q;
                    prev_valid_d = 1'b1;
                    state_d      = S_REPORT;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            chunk_q      <= '0;
            found_q      <= 1'b0;
            multi_q      <= 1'b0;
            idx_q        <= '0;
            rem_q        <= '0;
            row_q        <= '0;
            prev_idx_q   <= '0;
            prev_valid_q <= 1'b0;
            pos_valid_q  <= 1'b0;
            err_none_q   <= 1'b0;
            err_multi_q  <= 1'b0;
            pos_idx_q    <= '0;
            pos_row_q    <= '0;
            pos_col_q    <= '0;
            dir_q        <= DIR_NONE;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            chunk_q      <= chunk_d;
            found_q      <= found_d;
            multi_q      <= multi_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            row_q        <= row_d;
            prev_idx_q   <= prev_idx_d;
            prev_valid_q <= prev_valid_d;
            pos_valid_q  <= pos_valid_d;
            err_none_q   <= err_none_d;
            err_multi_q  <= err_multi_d;
            pos_idx_q    <= pos_idx_d;
            pos_row_q    <= pos_row_d;
            pos_col_q    <= pos_col_d;
            dir_q        <= dir_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign pos_valid = pos_valid_q;
    assign err_none  = err_none_q;
    assign err_multi = err_multi_q;
    assign pos_idx   = pos_idx_q;
    assign pos_row   = pos_row_q;
    assign pos_col   = pos_col_q;
    assign dir       = dir_q;

endmodule

// File: tb/tb_pacman_pos_decoder.sv
// Scoreboard bench for pacman_pos_decoder: model pushes expected reports, tasks pop and compare.
module tb_pacman_pos_decoder;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] frame;
    logic          frame_valid;
    logic          ready, pos_valid, err_none, err_multi;
    logic [9:0]    pos_idx;
    logic [6:0]    pos_row;
    logic [3:0]    pos_col;
    logic [2:0]    dir;

    pacman_pos_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .ready       (ready),
        .pos_valid   (pos_valid),
        .pos_idx     (pos_idx),
        .pos_row     (pos_row),
        .pos_col     (pos_col),
        .dir         (dir),
        .err_none    (err_none),
        .err_multi   (err_multi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       pv;
        logic       en;
        logic       em;
        logic [9:0] idx;
        logic [6:0] row;
        logic [3:0] col;
        logic [2:0] dir;
        logic [7:0] lat;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   b2b_stop;

    // Reference model state: last reported outputs and previous successful index.
    int m_prev, m_idx, m_row, m_col, m_dir;
    bit m_pv;

    function automatic string show(obs_t o);
        return $sformatf("pv=%0b en=%0b em=%0b idx=%0d row=%0d col=%0d dir=%0d lat=%0d",
                         o.pv, o.en, o.em, o.idx, o.row, o.col, o.dir, o.lat);
    endfunction

    function automatic logic [1023:0] onehot(input int id);
        logic [1023:0] f;
        f     = '0;
        f[id] = 1'b1;
        return f;
    endfunction

    function automatic int g(input int c);
        return (c * 97 + 13) % 1024;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_idx = 0; m_row = 0; m_col = 0; m_dir = 0; m_pv = 0;
        exp_q.delete();
    endtask

    // kind: 0 success, 1 no bit set, 2 several bits set
    task automatic push_exp(input int kind, input int id);
        obs_t e;
        int   d;
        if (kind == 0) begin
            d = id - m_prev;
            if (!m_pv)          m_dir = 0;
            else if (d == 0)    m_dir = 1;
            else if (d == 1)    m_dir = 2;
            else if (d == -1)   m_dir = 3;
            else if (d == 10)   m_dir = 4;
            else if (d == -10)  m_dir = 5;
            else                m_dir = 6;
            m_idx  = id;
            m_row  = id / 10;
            m_col  = id % 10;
            m_prev = id;
            m_pv   = 1;
        end
        e.pv  = (kind == 0);
        e.en  = (kind == 1);
        e.em  = (kind == 2);
        e.idx = m_idx[9:0];
        e.row = m_row[6:0];
        e.col = m_col[3:0];
        e.dir = m_dir[2:0];
        e.lat = (kind == 0) ? 8'(33 + m_row) : 8'd32;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic collect(input int t0, output obs_t o);
        bit got;
        got   = 0;
        o     = '0;
        o.lat = 8'hFF;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (pos_valid || err_none || err_multi) begin
                got   = 1;
                o.pv  = pos_valid;
                o.en  = err_none;
                o.em  = err_multi;
                o.idx = pos_idx;
                o.row = pos_row;
                o.col = pos_col;
                o.dir = dir;
                o.lat = 8'(cyc - t0);
            end
        end
    endtask

    task automatic send(input logic [1023:0] f, output obs_t o);
        bit ok;
        int t0;
        wait_ready(ok);
        frame       = f;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        t0          = cyc;
        frame_valid = 1'b0;
        frame       = {32{$urandom}};
        collect(t0, o);
        if (!ok) o.lat = 8'hFE;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, expected 1", ready);
        end
        n_cmp++;
        if ({pos_valid, err_none, err_multi} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b, expected 000", {pos_valid, err_none, err_multi});
        end
        n_cmp++;
        if ({pos_idx, pos_row, pos_col} !== 21'd0) begin
            n_fail++; $display("FAIL reset_pos: got idx=%0d row=%0d col=%0d, expected 0/0/0", pos_idx, pos_row, pos_col);
        end
        n_cmp++;
        if (dir !== 3'd0) begin
            n_fail++; $display("FAIL reset_dir: got %0d, expected 0", dir);
        end
    endtask

    task automatic test_idx0();
        obs_t o, e;
        push_exp(0, 0);
        send(onehot(0), o);
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL idx0: got %s, expected %s", show(o), show(e));
        end
    endtask

    task automatic test_sequence();
        int   seq[7]      = '{57, 58, 68, 67, 57, 57, 900};
        int   want_dir[7] = '{0, 2, 4, 3, 5, 1, 6};
        obs_t o, e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push_exp(0, seq[i]);
            send(onehot(seq[i]), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL seq[%0d]: got %s, expected %s", i, show(o), show(e));
            end
            n_cmp++;
            if (o.dir !== want_dir[i][2:0]) begin
                n_fail++; $display("FAIL seq_dir[%0d]: got %0d, expected %0d", i, o.dir, want_dir[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [1023:0] f;
        int            kind;
        int            id;
        obs_t          o, e;
        for (int i = 0; i < 6; i++) begin
            f = '0;
            case (i)
                0:       begin kind = 0; id = 57;   f = onehot(57); end
                1:       begin kind = 1; id = 0;    end
                2:       begin kind = 0; id = 58;   f = onehot(58); end
                3:       begin kind = 2; id = 0;    f = onehot(5) | onehot(700); end
                4:       begin kind = 2; id = 0;    f = onehot(33) | onehot(34); end
                default: begin kind = 0; id = 1023; f = onehot(1023); end
            endcase
            push_exp(kind, id);
            send(f, o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL err_case[%0d]: got %s, expected %s", i, show(o), show(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   pulses;
        obs_t o, e;
        wait_ready(ok);
        frame       = onehot(1000);
        frame_valid = 1'b1;
        @(posedge clk);
        #1 frame_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready, pos_valid, err_none, err_multi} !== 4'b1000) begin
            n_fail++; $display("FAIL midrst_ctrl: got %b, expected 1000", {ready, pos_valid, err_none, err_multi});
        end
        n_cmp++;
        if ({pos_idx, pos_row, pos_col, dir} !== 24'd0) begin
            n_fail++; $display("FAIL midrst_pos: got idx=%0d row=%0d col=%0d dir=%0d, expected all 0",
                               pos_idx, pos_row, pos_col, dir);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (150) begin
            @(negedge clk);
            if (pos_valid || err_none || err_multi) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL midrst_nopulse: got %0d pulses, expected 0", pulses);
        end
        push_exp(0, 12);
        send(onehot(12), o);
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL midrst_next: got %s, expected %s", show(o), show(e));
        end
        n_cmp++;
        if (o.dir !== 3'd0) begin
            n_fail++; $display("FAIL midrst_dir: got %0d, expected 0", o.dir);
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        int   acc;
        obs_t o, e;
        b2b_stop = 0;
        wait_ready(ok);
        frame       = onehot(g(cyc));
        frame_valid = 1'b1;
        acc         = cyc + 1;
        fork
            begin
                while (!b2b_stop) begin
                    @(posedge clk);
                    #1 frame = onehot(g(cyc));
                end
            end
        join_none
        for (int n = 0; n < 4; n++) begin
            push_exp(0, g(acc - 1));
            collect(acc, o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL b2b[%0d]: got %s, expected %s", n, show(o), show(e));
            end
            acc = acc + int'(e.lat) + 2;
        end
        frame_valid = 1'b0;
        b2b_stop    = 1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        frame_valid = 1'b0;
        frame       = '0;
        model_reset();
        test_reset();
        test_idx0();
        test_sequence();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
